// File: rtl/kfps2kb_command_scheduler.sv
// Two-requester command scheduler for the PS/2 send-data engine: arbitration, ACK/RESEND retry, timeouts.
// Optional: define KFPS2KB_RESEND_ON_TIMEOUT_EN to make an ACK_WAIT timeout consume a retry like 0xFE.
module kfps2kb_command_scheduler #(
    parameter logic [15:0] ACK_TIMEOUT = 16'd2000,
    parameter logic [7:0]  MAX_RETRY   = 8'd3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       peripheral_clock,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_grant,
    output logic       req0_done,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_grant,
    output logic       req1_done,
    output logic       cmd_error,
    output logic       busy,
    output logic       send_request,
    output logic [7:0] send_data,
    input  logic       sending_data_flag,
    input  logic       recv_valid,
    input  logic [7:0] recv_data
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEND      = 3'd1;
    localparam logic [2:0] S_SEND_WAIT = 3'd2;
    localparam logic [2:0] S_ACK_WAIT  = 3'd3;
    localparam logic [2:0] S_FINISH    = 3'd4;

    localparam logic [7:0] KB_ACK    = 8'hFA;
    localparam logic [7:0] KB_RESEND = 8'hFE;

    logic [2:0]  r_state;
    logic [2:0]  r_pclk_sync;
    logic [7:0]  r_send_data;
    logic        r_owner;
    logic        r_last_grant;
    logic [7:0]  r_retry_count;
    logic [15:0] r_tick_count;
    logic        r_error;
    logic        r_seen_flag;

    logic        w_tick;
    logic        w_timeout;
    logic        w_pick1;
    logic        w_grant0;
    logic        w_grant1;

    // Bits [1:0] are the synchroniser; bit 2 is the previous synchronised level for edge detection.
    assign w_tick    = r_pclk_sync[1] & ~r_pclk_sync[2];
    assign w_timeout = (r_tick_count == ACK_TIMEOUT);

    // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
    assign w_pick1  = req1_valid && (!req0_valid || !r_last_grant);
    assign w_grant0 = (r_state == S_IDLE) && req0_valid && !w_pick1;
    assign w_grant1 = (r_state == S_IDLE) && w_pick1;

    assign req0_grant   = w_grant0;
    assign req1_grant   = w_grant1;
    assign send_request = (r_state == S_SEND);
    assign send_data    = r_send_data;
    assign busy         = (r_state != S_IDLE);
    assign req0_done    = (r_state == S_FINISH) && !r_owner;
    assign req1_done    = (r_state == S_FINISH) && r_owner;
    assign cmd_error    = (r_state == S_FINISH) && r_error;

    // NOTE: all state updates use non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pclk_sync   <= 3'b000;
            r_send_data   <= 8'h00;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_retry_count <= 8'd0;
            r_tick_count  <= 16'd0;
            r_error       <= 1'b0;
            r_seen_flag   <= 1'b0;
        end else begin
            r_pclk_sync <= {r_pclk_sync[1:0], peripheral_clock};

            // Saturating tick counter; state-specific clears below take precedence.
            if (w_tick && !w_timeout) begin
                r_tick_count <= r_tick_count + 16'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_send_data   <= w_grant1 ? req1_data : req0_data;
                        r_owner       <= w_grant1;
                        r_last_grant  <= w_grant1;
                        r_retry_count <= 8'd0;
                        r_error       <= 1'b0;
                        r_state       <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_tick_count <= 16'd0;
                    r_seen_flag  <= 1'b0;
                    r_state      <= S_SEND_WAIT;
                end
                S_SEND_WAIT: begin
                    if (r_seen_flag && !sending_data_flag) begin
                        r_tick_count <= 16'd0;
                        r_state      <= S_ACK_WAIT;
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_state <= S_FINISH;
                    end else if (sending_data_flag) begin
                        r_seen_flag <= 1'b1;
                    end
                end
                S_ACK_WAIT: begin
                    if (recv_valid && recv_data == KB_ACK) begin
                        r_state <= S_FINISH;
                    end else if (recv_valid && recv_data == KB_RESEND) begin
                        if (r_retry_count < MAX_RETRY) begin
                            r_retry_count <= r_retry_count + 8'd1;
                            r_state       <= S_SEND;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= S_FINISH;
                        end
                    end else if (w_timeout) begin
`ifdef KFPS2KB_RESEND_ON_TIMEOUT_EN
                        if (r_retry_count < MAX_RETRY) begin
                            r_retry_count <= r_retry_count + 8'd1;
                            r_state       <= S_SEND;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= S_FINISH;
                        end
`else
                        r_error <= 1'b1;
                        r_state <= S_FINISH;
`endif
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kfps2kb_command_scheduler.sv
// Self-checking bench for kfps2kb_command_scheduler: vector table plus abort/reset sequence, scoreboarded by done pulses.
module tb_kfps2kb_command_scheduler;

    localparam logic [15:0] TB_TIMEOUT = 16'd10;
`ifdef KFPS2KB_RESEND_ON_TIMEOUT_EN
    localparam int TO_SENDS = 4;
`else
    localparam int TO_SENDS = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       peripheral_clock = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_grant;
    logic       req0_done;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_grant;
    logic       req1_done;
    logic       cmd_error;
    logic       busy;
    logic       send_request;
    logic [7:0] send_data;
    logic       sending_data_flag = 1'b0;
    logic       recv_valid = 1'b0;
    logic [7:0] recv_data = 8'h00;

    kfps2kb_command_scheduler #(
        .ACK_TIMEOUT(TB_TIMEOUT),
        .MAX_RETRY  (8'd3)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .peripheral_clock (peripheral_clock),
        .req0_valid       (req0_valid),
        .req0_data        (req0_data),
        .req0_grant       (req0_grant),
        .req0_done        (req0_done),
        .req1_valid       (req1_valid),
        .req1_data        (req1_data),
        .req1_grant       (req1_grant),
        .req1_done        (req1_done),
        .cmd_error        (cmd_error),
        .busy             (busy),
        .send_request     (send_request),
        .send_data        (send_data),
        .sending_data_flag(sending_data_flag),
        .recv_valid       (recv_valid),
        .recv_data        (recv_data)
    );

    always #5 clock = ~clock;
    always #200 peripheral_clock = ~peripheral_clock;   // one tick per 40 system clocks

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        int         n_fe;
        logic       final_fa;
        logic       junk;
        logic       exp_owner;
        logic       exp_err;
        int         exp_sends;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct {
        logic       owner;
        logic       err;
        int         sends;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks   = 0;
    int   n_fails    = 0;
    int   sends_seen = 0;
    int   done_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: counts transmit attempts and retires one expectation per done pulse.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            sends_seen = 0;
        end else begin
            if (send_request) begin
                sends_seen++;
                if (sb_q.size() > 0) check("send_data", send_data, sb_q[0].data);
            end
            if (req0_done || req1_done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_onehot", req0_done & req1_done, 0);
                    check("done_owner", req1_done, e.owner);
                    check("cmd_error", cmd_error, e.err);
                    check("send_count", sends_seen, e.sends);
                end
                sends_seen = 0;
                done_count++;
            end
        end
    end

    task automatic wait_grant(output logic ok, output logic g0, output logic g1);
        ok = 1'b0; g0 = 1'b0; g1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (req0_grant || req1_grant) begin
                ok = 1'b1; g0 = req0_grant; g1 = req1_grant;
                break;
            end
        end
        step(1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_send(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (send_request) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic sender_transfer();
        step(2);
        sending_data_flag = 1'b1;
        step(20);
        sending_data_flag = 1'b0;
        step(3);
    endtask

    task automatic respond(input logic [7:0] b);
        recv_valid = 1'b1;
        recv_data  = b;
        step(1);
        recv_valid = 1'b0;
    endtask

    task automatic run_vector(input vec_t v);
        exp_t e;
        logic ok, g0, g1;
        int   start;
        start   = done_count;
        e.owner = v.exp_owner;
        e.err   = v.exp_err;
        e.sends = v.exp_sends;
        e.data  = v.exp_data;
        sb_q.push_back(e);
        step(1);
        req0_valid = v.v0; req0_data = v.d0;
        req1_valid = v.v1; req1_data = v.d1;
        wait_grant(ok, g0, g1);
        check("grant_seen", ok, 1);
        if (!ok) begin
            void'(sb_q.pop_back());
            return;
        end
        check("grant_owner", {g1, g0}, v.exp_owner ? 2'b10 : 2'b01);
        for (int a = 0; a < v.exp_sends; a++) begin
            wait_send(ok);
            check("send_seen", ok, 1);
            if (!ok) break;
            sender_transfer();
            if (a < v.n_fe) begin
                respond(8'hFE);
            end else if (v.final_fa) begin
                if (v.junk) begin
                    respond(8'h12);
                    step(2);
                end
                respond(8'hFA);
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            if (done_count != start) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", ok, 1);
        @(negedge clock);
        check("busy_after_done", busy, 0);
    endtask

    vec_t vecs[8];

    initial begin
        logic ok, g0, g1;
        int   saved;

        // {v0, d0, v1, d1, n_fe, final_fa, junk, owner, err, sends, data}
        vecs[0] = '{1'b1, 8'hA0, 1'b1, 8'hB0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'hA0};
        vecs[1] = '{1'b1, 8'hC1, 1'b1, 8'hD1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 8'hD1};
        vecs[2] = '{1'b1, 8'hED, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'hED};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 8'hFF, 3, 1'b1, 1'b0, 1'b1, 1'b0, 4, 8'hFF};
        vecs[4] = '{1'b1, 8'hF4, 1'b0, 8'h00, 4, 1'b0, 1'b0, 1'b0, 1'b1, 4, 8'hF4};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h55, 0, 1'b0, 1'b0, 1'b1, 1'b1, TO_SENDS, 8'h55};
        vecs[6] = '{1'b1, 8'h33, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h33};
        vecs[7] = '{1'b1, 8'h66, 1'b1, 8'h77, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 8'h77};

        step(3);
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_send_request", send_request, 0);
        check("rst_send_data", send_data, 8'h00);
        check("rst_done", {req0_done, req1_done, cmd_error}, 3'b000);
        step(1);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vector(vecs[i]);

        // Abort a req0 command in ACK_WAIT; afterwards a tie must go to req0 again.
        saved = done_count;
        step(1);
        req0_valid = 1'b1; req0_data = 8'h3C;
        wait_grant(ok, g0, g1);
        check("abort_grant", {g1, g0}, 2'b01);
        wait_send(ok);
        check("abort_send_seen", ok, 1);
        check("abort_send_data", send_data, 8'h3C);
        sender_transfer();
        step(2);
        @(negedge clock);
        check("abort_busy_before", busy, 1);
        step(1);
        reset = 1'b1;
        step(1);
        @(negedge clock);
        check("abort_busy_in_reset", busy, 0);
        check("abort_send_request", send_request, 0);
        step(1);
        reset = 1'b0;
        step(50);
        check("abort_no_done", done_count, saved);

        run_vector('{1'b1, 8'h88, 1'b1, 8'h99, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'h88});
        run_vector('{1'b0, 8'h00, 1'b1, 8'hAA, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 8'hAA});

        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
